// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter for the MIPS data bus.
//   TXD      (TXD_ADDR) : write starts a frame when idle and enabled; read returns last byte.
//   UART_CON (CON_ADDR) : {27'b0, tx_busy, 1'b0, tx_done, 1'b0, tx_en}; a read clears tx_done.
// tx_irq is a level interrupt, tx_done & tx_en.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit (frame grows from 10 to 11 bit times).
module uart_tx_peripheral #(
   parameter int unsigned BAUD_DIV = 10417,
   parameter logic [31:0] TXD_ADDR = 32'h4000_0018,
   parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        tx_irq
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_baud_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_txd;
   logic               r_tx_en;
   logic               r_tx_done;

   logic               w_bit_last;
   logic               w_frame_end;
   logic               w_tx;
   logic               w_tx_busy;
   logic               w_txd_wr;
   logic               w_txd_accept;
   logic               w_con_wr;
   logic               w_con_rd;
   logic               w_unused;

   // Bus decode; TXD writes are only accepted while the line is idle.
   assign w_txd_wr     = wr && (addr == TXD_ADDR);
   assign w_con_wr     = wr && (addr == CON_ADDR);
   assign w_con_rd     = rd && (addr == CON_ADDR);
   assign w_tx_busy    = (r_state != S_IDLE);
   assign w_txd_accept = w_txd_wr && !w_tx_busy;
   assign w_bit_last   = (r_baud_cnt == BAUD_LAST);

   // Only the low byte of wdata is meaningful to this block.
   assign w_unused = &{1'b0, wdata[31:8]};

   // Frame state register; async reset aborts a frame and returns the line to idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and serial line value, decoded from the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_tx        = 1'b1;
      w_frame_end = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_txd_accept && r_tx_en) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx = 1'b0;
            if (w_bit_last) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            w_tx = r_txd[r_bit_idx];
            if (w_bit_last && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            w_tx = ^r_txd;
            if (w_bit_last) begin
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            w_tx = 1'b1;
            if (w_bit_last) begin
               w_state_nxt = S_IDLE;
               w_frame_end = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Baud counter: runs 0..BAUD_DIV-1 in every non-idle state, parked at 0 when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_baud_cnt <= '0;
      end else if (!w_tx_busy || w_bit_last) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + CNT_ONE;
      end
   end

   // Data bit index: advances at the end of each data bit, wraps to 0 after bit 7.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_idx <= 3'd0;
      end else if (r_state != S_DATA) begin
         r_bit_idx <= 3'd0;
      end else if (w_bit_last) begin
         r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

   // TXD holding register; frozen for the whole frame because busy writes are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_txd <= 8'h00;
      end else if (w_txd_accept) begin
         r_txd <= wdata[7:0];
      end
   end

   // Transmit enable; changing it mid-frame only masks the interrupt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_en <= 1'b1;
      end else if (w_con_wr) begin
         r_tx_en <= wdata[0];
      end
   end

   // Done flag: set at end of stop bit (set beats a simultaneous clear).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_done <= 1'b0;
      end else if (w_frame_end) begin
         r_tx_done <= 1'b1;
      end else if (w_con_rd || w_txd_accept) begin
         r_tx_done <= 1'b0;
      end
   end

   // Combinational read mux; a same-cycle write is not yet visible here.
   always_comb begin
      rdata = 32'h0000_0000;
      if (addr == TXD_ADDR) begin
         rdata = {24'h00_0000, r_txd};
      end else if (addr == CON_ADDR) begin
         rdata = {27'h000_0000, w_tx_busy, 1'b0, r_tx_done, 1'b0, r_tx_en};
      end
   end

   assign tx     = w_tx;
   assign tx_irq = r_tx_done & r_tx_en;

endmodule
